// File: rtl/gcd_control.sv
// gcd_control: sequencer for the 16-bit subtractive GCD datapath.
// Accepts operand pairs over a valid/ready handshake and steers the datapath
// mux selects and register enables from the zero/lt flags. It presents the
// result over a valid/ready handshake with an operation count and a timeout flag.
module gcd_control #(
  parameter int unsigned CW       = 16,
  parameter int unsigned MAX_ITER = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          zero,
  input  logic          lt,
  output logic [1:0]    mux_sel_A,
  output logic          mux_sel_B,
  output logic          A_reg_en,
  output logic          B_reg_en,
  output logic [CW-1:0] iter_count,
  output logic          err
);

  localparam logic [CW-1:0] LP_MAX_ITER = CW'(MAX_ITER);

  // Datapath A-mux select encodings
  localparam logic [1:0] SEL_A_IN   = 2'b00;
  localparam logic [1:0] SEL_A_B    = 2'b01;
  localparam logic [1:0] SEL_A_SUB  = 2'b10;
  localparam logic [1:0] SEL_A_HOLD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_iter;
  logic [CW-1:0] w_iter_d;
  logic          r_err;
  logic          w_err_d;
  logic          w_busy;
  logic          w_limit;

  // Work remains while A < B (swap) or B != 0 (subtract)
  assign w_busy  = lt || !zero;
  assign w_limit = (r_iter == LP_MAX_ITER);

  // State, operation counter and error flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_iter  <= w_iter_d;
      r_err   <= w_err_d;
    end
  end

  // Next state plus same-cycle datapath controls (the datapath samples on the same edge)
  always_comb begin
    w_next    = r_state;
    w_iter_d  = r_iter;
    w_err_d   = r_err;
    mux_sel_A = SEL_A_HOLD;
    mux_sel_B = 1'b0;
    A_reg_en  = 1'b0;
    B_reg_en  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          mux_sel_A = SEL_A_IN;
          mux_sel_B = 1'b0;
          A_reg_en  = 1'b1;
          B_reg_en  = 1'b1;
          w_iter_d  = '0;
          w_err_d   = 1'b0;
          w_next    = S_CALC;
        end
      end

      S_CALC: begin
        if (w_busy && w_limit) begin
          // Out of budget: abort without touching the datapath
          w_err_d = 1'b1;
          w_next  = S_DONE;
        end else if (lt) begin
          mux_sel_A = SEL_A_B;
          mux_sel_B = 1'b1;
          A_reg_en  = 1'b1;
          B_reg_en  = 1'b1;
          w_iter_d  = r_iter + CW'(1);
        end else if (!zero) begin
          mux_sel_A = SEL_A_SUB;
          A_reg_en  = 1'b1;
          w_iter_d  = r_iter + CW'(1);
        end else begin
          w_err_d = 1'b0;
          w_next  = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Datapath registers must hold while reset is applied
    if (rst) begin
      mux_sel_A = SEL_A_HOLD;
      mux_sel_B = 1'b0;
      A_reg_en  = 1'b0;
      B_reg_en  = 1'b0;
    end
  end

  // Handshake outputs decode the state register only
  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign iter_count = r_iter;
  assign err        = r_err;

endmodule

// File: tb/tb_gcd_control.sv
// Scoreboard bench for gcd_control with a behavioural GCD datapath per instance.
// Instance 0 uses default parameters; instance 1 uses MAX_ITER = 3.
module tb_gcd_control;

  logic        clk;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        zero      [2];
  logic        lt        [2];
  logic [1:0]  msa       [2];
  logic        mb        [2];
  logic        aen       [2];
  logic        ben       [2];
  logic [15:0] iter      [2];
  logic        err       [2];
  logic [15:0] in_a      [2];
  logic [15:0] in_b      [2];
  logic [15:0] dp_a      [2];
  logic [15:0] dp_b      [2];

  typedef struct {
    logic [15:0] vout;
    logic [15:0] iter;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ops[$];   // expected op sequence on instance 0: 1 = sub, 2 = swap

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc [2];
  logic prev_ov [2];
  exp_t cur     [2];

  gcd_control u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .zero(zero[0]), .lt(lt[0]),
    .mux_sel_A(msa[0]), .mux_sel_B(mb[0]),
    .A_reg_en(aen[0]), .B_reg_en(ben[0]),
    .iter_count(iter[0]), .err(err[0])
  );

  gcd_control #(.CW(16), .MAX_ITER(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .zero(zero[1]), .lt(lt[1]),
    .mux_sel_A(msa[1]), .mux_sel_B(mb[1]),
    .A_reg_en(aen[1]), .B_reg_en(ben[1]),
    .iter_count(iter[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: A/B registers, muxes and flags
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (aen[i]) begin
        case (msa[i])
          2'b00:   dp_a[i] <= in_a[i];
          2'b01:   dp_a[i] <= dp_b[i];
          2'b10:   dp_a[i] <= dp_a[i] - dp_b[i];
          default: dp_a[i] <= dp_a[i];
        endcase
      end
      if (ben[i]) dp_b[i] <= mb[i] ? dp_a[i] : in_b[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      zero[i] = (dp_b[i] == 16'd0);
      lt[i]   = (dp_a[i] < dp_b[i]);
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: tracks accepts, pops the scoreboard on each new result, checks stability and ops
  always @(negedge clk) begin
    if (rst) begin
      prev_ov[0] = 1'b0;
      prev_ov[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i] && in_ready[i]) acc_cyc[i] = cyc + 1;
        if (out_valid[i]) begin
          if (!prev_ov[i]) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
              check($sformatf("unexpected_result%0d", i), 1, 0);
            end else begin
              cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("vout%0d", i), dp_a[i], cur[i].vout);
              check($sformatf("iter_count%0d", i), iter[i], cur[i].iter);
              check($sformatf("err%0d", i), err[i], cur[i].err);
              check($sformatf("latency%0d", i), cyc - acc_cyc[i], cur[i].lat);
            end
          end else begin
            check($sformatf("hold_vout%0d", i), dp_a[i], cur[i].vout);
            check($sformatf("hold_iter%0d", i), iter[i], cur[i].iter);
            check($sformatf("hold_err%0d", i), err[i], cur[i].err);
          end
        end
        prev_ov[i] = out_valid[i];
      end
      if (aen[0] && !ben[0] && msa[0] == 2'b10) begin
        if (ops.size() == 0) check("unexpected_sub", 1, 0);
        else check("op_sub", 1, ops.pop_front());
      end else if (aen[0] && ben[0] && msa[0] == 2'b01 && mb[0]) begin
        if (ops.size() == 0) check("unexpected_swap", 2, 0);
        else check("op_swap", 2, ops.pop_front());
      end
    end
  end

  task automatic run_job(input int i, input int a, input int b, input int ev, input int ei,
                         input int ee, input int lat, input int hold, input bit pulse);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready[i] && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready_wait", n < 50, 1);
    e.vout = 16'(ev); e.iter = 16'(ei); e.err = ee[0]; e.lat = lat;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    in_a[i] = 16'(a); in_b[i] = 16'(b); in_valid[i] = 1'b1;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    if (pulse) begin
      // Spurious request while busy must not reload operands
      in_a[i] = 16'd999; in_b[i] = 16'd333; in_valid[i] = 1'b1;
    end
    n = 0;
    while (!out_valid[i] && n < 200) begin @(posedge clk); #1; n++; end
    check("out_valid_wait", n < 200, 1);
    for (int h = 0; h < hold; h++) begin
      check("in_ready_low_in_done", in_ready[i], 0);
      @(posedge clk); #1;
      check("out_valid_held", out_valid[i], 1);
    end
    in_valid[i] = 1'b0;
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
    check("in_ready_after_ack", in_ready[i], 1);
    check("out_valid_after_ack", out_valid[i], 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
      acc_cyc[i] = 0; prev_ov[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_en", aen[0], 0);
    check("rst_b_en", ben[0], 0);
    check("rst_mux_a", msa[0], 3);
    check("rst_mux_b", mb[0], 0);
    rst = 1'b0;
    check("reset_in_ready", in_ready[0], 1);
    check("reset_out_valid", out_valid[0], 0);
    check("reset_iter", iter[0], 0);
    check("reset_err", err[0], 0);
    check("reset_in_ready1", in_ready[1], 1);

    // (12,8): sub, swap, sub, sub, swap -> 4
    ops.push_back(1); ops.push_back(2); ops.push_back(1); ops.push_back(1); ops.push_back(2);
    run_job(0, 12, 8, 4, 5, 0, 6, 0, 0);
    // (0,5): one swap -> 5
    ops.push_back(2);
    run_job(0, 0, 5, 5, 1, 0, 2, 0, 0);
    // (7,0): no operations
    run_job(0, 7, 0, 7, 0, 0, 1, 0, 0);
    // (0,0): finishes immediately with 0
    run_job(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // (21,14) with backpressure and spurious in_valid pulses
    ops.push_back(1); ops.push_back(2); ops.push_back(1); ops.push_back(1); ops.push_back(2);
    run_job(0, 21, 14, 7, 5, 0, 6, 10, 1);

    // MAX_ITER = 3: (100,1) times out after 3 subtracts
    run_job(1, 100, 1, 97, 3, 1, 4, 2, 0);
    // Exactly MAX_ITER operations completes normally and clears err
    run_job(1, 8, 4, 4, 3, 0, 4, 0, 0);

    // Reset during CALC after sub and swap of (12,8)
    ops.push_back(1); ops.push_back(2);
    in_a[0] = 16'd12; in_b[0] = 16'd8; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("calc_before_reset", in_ready[0] || out_valid[0], 0);
    rst = 1'b1;
    #1;
    check("midrst_a_en", aen[0], 0);
    check("midrst_b_en", ben[0], 0);
    check("midrst_mux_a", msa[0], 3);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready[0], 1);
    check("midrst_out_valid", out_valid[0], 0);
    check("midrst_iter", iter[0], 0);
    check("midrst_err", err[0], 0);

    // Recovery after reset
    run_job(0, 7, 0, 7, 0, 0, 1, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    check("ops_empty", ops.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_control.md
# gcd_control

Control unit for the 16-bit subtractive GCD engine. It sequences the existing GCD datapath: it accepts operand pairs through a valid/ready input handshake and drives the datapath's mux selects and register enables from the `zero` and `lt` status flags. It presents the result through a valid/ready output handshake and reports an iteration count and a timeout error. It sits between the upstream requester and the datapath, one controller per datapath instance.

## Interface
- `CW`, default 16: width of the iteration counter.
- `MAX_ITER`, default 16'hFFFF: iteration limit (swap plus subtract operations) before abort; must fit in `CW` bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: upstream operand pair on datapath `inA`/`inB` is valid.
- `in_ready`  out  1: controller can accept operands.
- `out_valid`  out  1: datapath `vout` holds a result.
- `out_ready`  in  1: downstream consumes the result.
- `zero`  in  1: datapath flag, B == 0.
- `lt`  in  1: datapath flag, A < B.
- `mux_sel_A`  out  2: 00 = inA, 01 = B, 10 = A−B, 11 = hold A.
- `mux_sel_B`  out  1: 0 = inB, 1 = A.
- `A_reg_en`  out  1: datapath A register load enable.
- `B_reg_en`  out  1: datapath B register load enable.
- `iter_count`  out  CW: operations performed for the current or last job.
- `err`  out  1: last result aborted on timeout; valid while `out_valid`.

## Operation
- States: IDLE, CALC, DONE. The state register and `iter_count` are registered. `err` is a registered flag. Handshake outputs decode the state only (Moore). Datapath control outputs are combinational from the state, `zero` and `lt` (Mealy), because the datapath registers sample on the same edge.
- IDLE: `in_ready` = 1.
  - If `in_valid` = 1: drive `mux_sel_A` = 00, `mux_sel_B` = 0, and both enables high (load).
  - On that edge: clear `iter_count` and `err`, then go to CALC.
  - Otherwise: both enables low.
- CALC, evaluated in this priority order:
  1. `lt` = 1: swap. Drive `mux_sel_A` = 01, `mux_sel_B` = 1, both enables high, and increment `iter_count`.
  2. `zero` = 0: subtract. Drive `mux_sel_A` = 10, `A_reg_en` = 1, `B_reg_en` = 0, and increment `iter_count`.
  3. `zero` = 1: finished. Both enables low; go to DONE with `err` = 0.
  - Timeout: if `iter_count` == `MAX_ITER` and `lt` or `!zero` holds, perform no operation (enables low) and go to DONE with `err` = 1.
- DONE: `out_valid` = 1, enables low, `mux_sel_A` = 11. `vout` = A is stable. On `out_valid` && `out_ready`, go to IDLE.
- Selects that do not matter (enable low) are driven to `mux_sel_A` = 11 and `mux_sel_B` = 0.
- `iter_count` never wraps. The timeout check guarantees `iter_count` ≤ `MAX_ITER`.
- Operand edge cases:
  - A = 0, B = 0: finishes immediately with result 0.
  - A = 0, B = n: one swap, then result n.
  - A = n, B = 0: result n with 0 operations.

## Timing
- Reset values: state IDLE, `in_ready` = 1 from the first cycle after reset, `out_valid` = 0, `err` = 0, `iter_count` = 0.
- During the reset cycle: enables = 0, `mux_sel_A` = 11, `mux_sel_B` = 0. Datapath A and B are not reset and simply hold.
- Reset mid-CALC or mid-DONE: return to IDLE on that edge. Any pending result is discarded with no `out_valid`.
- Latency: let accept edge = edge where `in_valid` && `in_ready`, and N = number of operations. `out_valid` rises N+1 cycles after the accept edge, i.e. N operation cycles plus one zero-detect cycle.
- Back-to-back jobs: after the `out_ready` edge, `in_ready` = 1 in the next cycle. The minimum gap between consecutive accepts is N+3 cycles.
- `in_valid` outside IDLE is ignored. `out_ready` outside DONE is ignored.
- `out_valid` holds, with `vout`, `iter_count` and `err` stable, until `out_ready`.

## Test plan
- Reset, then (12, 8):
  - Sequence is sub, swap, sub, sub, swap.
  - `out_valid` 6 cycles after accept.
  - `vout` = 4, `iter_count` = 5, `err` = 0.
- (0, 5):
  - One swap, `vout` = 5, `iter_count` = 1.
- (7, 0):
  - `vout` = 7, `iter_count` = 0, `out_valid` 1 cycle after accept.
- (0, 0):
  - `vout` = 0, `iter_count` = 0.
- Backpressure, (21, 14):
  - Hold `out_ready` = 0 for 10 cycles.
  - `out_valid` stays 1 and `vout` = 7 stays stable.
  - `in_valid` pulses during CALC and DONE are ignored.
  - The next job is accepted only after the `out_ready` edge.
- `MAX_ITER` = 3, (100, 1):
  - `err` = 1 and `iter_count` = 3.
  - Separately, assert `rst` during CALC: next cycle state is IDLE, `in_ready` = 1, `out_valid` = 0, `iter_count` = 0.
